// File: rtl/wb_pkg.sv
// Shared writeback definitions: register-address width and the result entry type
// exchanged between the LSU, decode and the writeback arbiter.
package wb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned WIDTH      = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WIDTH-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered LSU results. Count is registered; ready is a
// registered !full so the producer handshake has no combinational input path.
module wb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned EW    = 37
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [EW-1:0] din,
   output logic          ready,
   output logic          empty,
   output logic [EW-1:0] head
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   count_q, count_d;
   logic          ready_q;
   logic          full;
   logic          do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rptr_q];
   assign ready   = ready_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         ready_q <= (count_d != (PW+1)'(DEPTH));
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results take priority over buffered LSU
// results; a busy scoreboard tracks destinations of outstanding long-latency ops.
module writeback_arbiter
   import wb_pkg::REG_ADDR_W;
   import wb_pkg::NUM_REGS;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [WIDTH-1:0]      alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [WIDTH-1:0]      lsu_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] rs1addr,
   input  logic [REG_ADDR_W-1:0] rs2addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  enw,
   output logic [REG_ADDR_W-1:0] rdaddr,
   output logic [WIDTH-1:0]      rddata
);

   localparam int unsigned EW = REG_ADDR_W + WIDTH;

   logic                  fifo_empty;
   logic [EW-1:0]         fifo_head;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [WIDTH-1:0]      head_data;

   logic                  enw_q, out_lsu_q;
   logic [REG_ADDR_W-1:0] rdaddr_q;
   logic [WIDTH-1:0]      rddata_q;
   logic [NUM_REGS-1:0]   busy_q, busy_d;

   wb_fifo #(
      .DEPTH (DEPTH),
      .EW    (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lsu_valid && lsu_ready),
      .pop   (!alu_valid),
      .din   ({lsu_rd, lsu_data}),
      .ready (lsu_ready),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign head_rd   = fifo_head[EW-1 -: REG_ADDR_W];
   assign head_data = fifo_head[WIDTH-1:0];

   // x0 results are still consumed from their source but never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         enw_q     <= 1'b0;
         rdaddr_q  <= '0;
         rddata_q  <= '0;
         out_lsu_q <= 1'b0;
      end else if (alu_valid) begin
         enw_q     <= (alu_rd != '0);
         rdaddr_q  <= alu_rd;
         rddata_q  <= alu_data;
         out_lsu_q <= 1'b0;
      end else if (!fifo_empty) begin
         enw_q     <= (head_rd != '0);
         rdaddr_q  <= head_rd;
         rddata_q  <= head_data;
         out_lsu_q <= 1'b1;
      end else begin
         enw_q     <= 1'b0;
         out_lsu_q <= 1'b0;
      end
   end

   // Clear on the LSU commit edge, then set, so a same-edge re-issue stays busy.
   always_comb begin
      busy_d = busy_q;
      if (enw_q && out_lsu_q) busy_d[rdaddr_q] = 1'b0;
      if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy = busy_q[rs1addr];
   assign rs2_busy = busy_q[rs2addr];
   assign enw      = enw_q;
   assign rdaddr   = rdaddr_q;
   assign rddata   = rddata_q;

endmodule
